msm_bucket_sched: RTL

- Parametrised successor of the MSM bucket-accumulation controller.
- Each cycle, picks one operation from the point_mem head (pm) and the result_buffer head (rb) and drives the PADD operand selects.
- Carries the bucket ID down a PADD_LATENCY valid/ID pipe.
- New over the previous generation:
  - in-flight bucket-ID scoreboard that stalls read-after-write hazards;
  - explicit IDLE/LOAD/RUN/DRAIN/DONE run control with an msm_done pulse;
  - hazard stall counter.

---
 rtl/msm_pkg.sv | 28 ++
 rtl/msm_id_scoreboard.sv | 60 ++++++
 rtl/msm_bucket_sched.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/msm_pkg.sv
// Shared definitions for the MSM bucket scheduler: ID width, PADD operand
// select encodings, run-control states and a small state helper.
package msm_pkg;

    localparam int ID_W = 4;

    localparam logic [2:0] SEL_A_RB  = 3'd0;
    localparam logic [2:0] SEL_A_BA  = 3'd1;
    localparam logic [2:0] SEL_A_BB  = 3'd2;
    localparam logic [2:0] SEL_A_BUB = 3'd3;

    localparam logic [2:0] SEL_B_RB  = 3'd0;
    localparam logic [2:0] SEL_B_PM  = 3'd1;
    localparam logic [2:0] SEL_B_BUB = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic can_issue(input state_e st);
        return (st == ST_RUN) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/msm_id_scoreboard.sv
// In-flight bucket-ID scoreboard: one bit per ID, set on issue, cleared when
// the PADD result for that ID emerges; a same-cycle set of the same ID wins.
module msm_id_scoreboard
    import msm_pkg::*;
#(
    parameter int WIDTH_ID = ID_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       set_en,
    input  logic [WIDTH_ID-1:0]        set_id,
    input  logic                       clr_en,
    input  logic [WIDTH_ID-1:0]        clr_id,
    output logic [(1<<WIDTH_ID)-1:0]   bits,
    output logic [WIDTH_ID:0]          count,
    output logic                       empty
);

    localparam int DEPTH = 1 << WIDTH_ID;
    localparam int CW    = WIDTH_ID + 1;

    function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    logic [DEPTH-1:0] bits_r;
    logic [DEPTH-1:0] set_mask_s;
    logic [DEPTH-1:0] clr_mask_s;
    logic [DEPTH-1:0] bits_next_s;
    logic [CW-1:0]    count_r;
    logic             empty_r;

    // Clear is applied before set so a coincident set of the same ID survives.
    assign set_mask_s  = set_en ? ({{(DEPTH-1){1'b0}}, 1'b1} << set_id) : {DEPTH{1'b0}};
    assign clr_mask_s  = clr_en ? ({{(DEPTH-1){1'b0}}, 1'b1} << clr_id) : {DEPTH{1'b0}};
    assign bits_next_s = (bits_r & ~clr_mask_s) | set_mask_s;

    // Occupancy vector with registered count and empty flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_r  <= {DEPTH{1'b0}};
            count_r <= {CW{1'b0}};
            empty_r <= 1'b1;
        end else begin
            bits_r  <= bits_next_s;
            count_r <= popcount(bits_next_s);
            empty_r <= (bits_next_s == {DEPTH{1'b0}});
        end
    end

    assign bits  = bits_r;
    assign count = count_r;
    assign empty = empty_r;

endmodule

// File: rtl/msm_bucket_sched.sv
// MSM bucket-accumulation scheduler: arbitrates point_mem and result_buffer
// heads into PADD issues, tracks in-flight IDs and sequences a run.
module msm_bucket_sched
    import msm_pkg::*;
#(
    parameter int WIDTH_ID     = ID_W,
    parameter int PADD_LATENCY = 21,
    parameter int RB_LAT       = 2,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                load_done,
    input  logic                src_done,
    input  logic                pm_vld,
    input  logic [WIDTH_ID-1:0] pm_id,
    input  logic                p_bucket_a,
    input  logic                rb_vld,
    input  logic [WIDTH_ID-1:0] rb_id,
    input  logic                r_bucket_b,
    output logic                load_start,
    output logic                msm_start,
    output logic                pm_pop,
    output logic                rb_r_req,
    output logic [2:0]          padd_in_a_sel,
    output logic [2:0]          padd_in_b_sel,
    output logic                padd_out_vld,
    output logic [WIDTH_ID-1:0] padd_out_id,
    output logic                busy,
    output logic                msm_done,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam int DEPTH = 1 << WIDTH_ID;
    localparam int QW    = $clog2(RB_LAT + 2);

    state_e                state_r;
    state_e                state_next_s;
    logic [QW-1:0]         quiet_cnt_r;
    logic [QW-1:0]         quiet_cnt_next_s;

    logic [DEPTH-1:0]      sb_bits_s;
    logic [WIDTH_ID:0]     sb_count_s;
    logic                  sb_empty_s;

    logic                  hp_s;
    logic                  hr_s;
    logic                  quiet_s;
    logic [2:0]            a_sel_s;
    logic [2:0]            b_sel_s;
    logic                  pm_pop_s;
    logic                  rb_pop_s;
    logic                  issue_s;
    logic [WIDTH_ID-1:0]   issue_id_s;
    logic                  stall_s;

    logic                  issue_vld_r;
    logic [WIDTH_ID-1:0]   issue_id_r;
    logic [PADD_LATENCY-1:0] pipe_vld_r;
    logic [WIDTH_ID-1:0]   pipe_id_r [PADD_LATENCY];

    logic                  load_start_r;
    logic                  msm_start_r;
    logic                  pm_pop_r;
    logic                  rb_pop_r;
    logic [2:0]            a_sel_r;
    logic [2:0]            b_sel_r;
    logic                  busy_r;
    logic                  msm_done_r;
    logic [CNT_W-1:0]      stall_cnt_r;

    msm_id_scoreboard #(
        .WIDTH_ID (WIDTH_ID)
    ) u_sb (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_en (issue_s),
        .set_id (issue_id_s),
        .clr_en (pipe_vld_r[PADD_LATENCY-1]),
        .clr_id (pipe_id_r[PADD_LATENCY-1]),
        .bits   (sb_bits_s),
        .count  (sb_count_s),
        .empty  (sb_empty_s)
    );

    assign hp_s = pm_vld & sb_bits_s[pm_id];
    assign hr_s = rb_vld & sb_bits_s[rb_id];

    // Both occupancy views must agree the scoreboard is empty before draining.
    assign quiet_s = !pm_vld && !rb_vld && sb_empty_s && (sb_count_s == {(WIDTH_ID+1){1'b0}})
                     && !issue_vld_r && (pipe_vld_r == {PADD_LATENCY{1'b0}});

    // Issue arbitration: first matching rule wins.
    always_comb begin
        a_sel_s    = SEL_A_BUB;
        b_sel_s    = SEL_B_BUB;
        pm_pop_s   = 1'b0;
        rb_pop_s   = 1'b0;
        issue_s    = 1'b0;
        issue_id_s = {WIDTH_ID{1'b0}};
        stall_s    = 1'b0;
        if (can_issue(state_r)) begin
            if (pm_vld && rb_vld && (pm_id == rb_id) && !hp_s && !hr_s) begin
                a_sel_s    = SEL_A_RB;
                b_sel_s    = SEL_B_PM;
                pm_pop_s   = 1'b1;
                rb_pop_s   = 1'b1;
                issue_s    = 1'b1;
                issue_id_s = pm_id;
            end else if (pm_vld && !hp_s && p_bucket_a) begin
                a_sel_s    = SEL_A_BA;
                b_sel_s    = SEL_B_PM;
                pm_pop_s   = 1'b1;
                issue_s    = 1'b1;
                issue_id_s = pm_id;
            end else if (rb_vld && !hr_s && r_bucket_b) begin
                a_sel_s    = SEL_A_BB;
                b_sel_s    = SEL_B_RB;
                rb_pop_s   = 1'b1;
                issue_s    = 1'b1;
                issue_id_s = rb_id;
            end else if (pm_vld && !hp_s) begin
                pm_pop_s   = 1'b1;
            end else if (rb_vld && !hr_s) begin
                rb_pop_s   = 1'b1;
            end else begin
                stall_s    = hp_s | hr_s;
            end
        end else begin
            stall_s = 1'b0;
        end
    end

    // Run-control next state and drain quiet-cycle counter.
    always_comb begin
        state_next_s     = state_r;
        quiet_cnt_next_s = quiet_cnt_r;
        case (state_r)
            ST_IDLE: begin
                quiet_cnt_next_s = {QW{1'b0}};
                if (start) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_done) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                quiet_cnt_next_s = {QW{1'b0}};
                if (src_done) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!quiet_s) begin
                    quiet_cnt_next_s = {QW{1'b0}};
                end else if (quiet_cnt_r == QW'(RB_LAT)) begin
                    quiet_cnt_next_s = {QW{1'b0}};
                    state_next_s     = ST_DONE;
                end else begin
                    quiet_cnt_next_s = quiet_cnt_r + {{(QW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s     = ST_IDLE;
                quiet_cnt_next_s = {QW{1'b0}};
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            quiet_cnt_r <= {QW{1'b0}};
        end else begin
            state_r     <= state_next_s;
            quiet_cnt_r <= quiet_cnt_next_s;
        end
    end

    // Registered decision, issue stage and in-flight ID pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_pop_r    <= 1'b0;
            rb_pop_r    <= 1'b0;
            a_sel_r     <= SEL_A_BUB;
            b_sel_r     <= SEL_B_BUB;
            issue_vld_r <= 1'b0;
            issue_id_r  <= {WIDTH_ID{1'b0}};
            pipe_vld_r  <= {PADD_LATENCY{1'b0}};
            for (int i = 0; i < PADD_LATENCY; i++) begin
                pipe_id_r[i] <= {WIDTH_ID{1'b0}};
            end
        end else begin
            pm_pop_r     <= pm_pop_s;
            rb_pop_r     <= rb_pop_s;
            a_sel_r      <= a_sel_s;
            b_sel_r      <= b_sel_s;
            issue_vld_r  <= issue_s;
            issue_id_r   <= issue_id_s;
            pipe_vld_r   <= {pipe_vld_r[PADD_LATENCY-2:0], issue_vld_r};
            pipe_id_r[0] <= issue_id_r;
            for (int i = 1; i < PADD_LATENCY; i++) begin
                pipe_id_r[i] <= pipe_id_r[i-1];
            end
        end
    end

    // Handshake delays, status flags and saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_start_r <= 1'b0;
            msm_start_r  <= 1'b0;
            busy_r       <= 1'b0;
            msm_done_r   <= 1'b0;
            stall_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            load_start_r <= start;
            msm_start_r  <= load_done;
            busy_r       <= (state_next_s != ST_IDLE);
            msm_done_r   <= (state_next_s == ST_DONE);
            if ((state_r == ST_IDLE) && start) begin
                stall_cnt_r <= {CNT_W{1'b0}};
            end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign load_start    = load_start_r;
    assign msm_start     = msm_start_r;
    assign pm_pop        = pm_pop_r;
    assign rb_r_req      = rb_pop_r;
    assign padd_in_a_sel = a_sel_r;
    assign padd_in_b_sel = b_sel_r;
    assign padd_out_vld  = pipe_vld_r[PADD_LATENCY-1];
    assign padd_out_id   = pipe_id_r[PADD_LATENCY-1];
    assign busy          = busy_r;
    assign msm_done      = msm_done_r;
    assign stall_cnt     = stall_cnt_r;

endmodule
